// File: rtl/dec_pkg.sv
// dec_pkg: shared sizing, FSM states and event-table entry type for the RS decoder correction stage.
package dec_pkg;
  localparam int W      = 10;
  localparam int T      = 11;
  localparam int N      = 544;
  localparam int LANES  = 32;
  localparam int POS_W  = 10;
  localparam int NBEATS = (N + LANES - 1) / LANES;
  localparam int CNT_W  = $clog2(T + 1);
  localparam int BEAT_W = $clog2(NBEATS);
  typedef enum logic [1:0] {IDLE, COLLECT, CORRECT} s3_state_e;
  typedef struct packed {
    logic             vld;
    logic [POS_W-1:0] pos;
    logic [W-1:0]     y;
  } err_evt_t;
endpackage

// File: rtl/corr_lane_xor.sv
// corr_lane_xor: XOR of all valid event magnitudes whose position matches this lane's symbol index.
module corr_lane_xor
  import dec_pkg::*;
(
  input  err_evt_t [T-1:0] tbl,
  input  logic [POS_W:0]   idx,
  output logic [W-1:0]     mask
);
  always_comb begin
    mask = '0;
    for (int i = 0; i < T; i++)
      mask = (tbl[i].vld && {1'b0, tbl[i].pos} == idx && idx < (POS_W+1)'(N)) ? mask ^ tbl[i].y : mask;
  end
endmodule

// File: rtl/dec_correct_s3.sv
// dec_correct_s3: RS decoder stage 3 -- collects Forney error events into a table,
// then streams the delayed codeword through, XOR-correcting matching symbols.
module dec_correct_s3
  import dec_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               err_cnt_vld_i,
  input  logic [POS_W-1:0]   err_cnt_i,
  input  logic               dec_fail_i,
  input  logic               s2_vld_i,
  output logic               s3_rdy_o,
  input  logic [POS_W-1:0]   pos_i,
  input  logic [W-1:0]       y_i,
  input  logic               den_zero_i,
  input  logic               cw_vld_i,
  output logic               cw_rdy_o,
  input  logic [LANES*W-1:0] cw_data_i,
  input  logic               cw_last_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [LANES*W-1:0] out_data_o,
  output logic               out_last_o,
  output logic               out_fail_o
);
  s3_state_e state, state_nx;
  err_evt_t [T-1:0] tbl;
  logic [POS_W-1:0] coll, err_cnt;
  logic [BEAT_W-1:0] beat;
  logic cnt_lat, fail, ev, cnt_v, cw_fire, dup, ev_bad, last_beat, frame_err, fail_now, done;
  logic [LANES*W-1:0] fixed;

  // Ready lines are masked during flush so nothing is handshaken and then silently dropped.
  assign s3_rdy_o  = rst_ni && !flush_i &&
                     (state == IDLE || (state == COLLECT && !(cnt_lat && coll >= err_cnt)));
  assign cw_rdy_o  = rst_ni && !flush_i && state == CORRECT && (!out_vld_o || out_rdy_i);
  assign ev        = s2_vld_i && s3_rdy_o;
  assign cw_fire   = cw_vld_i && cw_rdy_o;
  assign cnt_v     = err_cnt_vld_i && !cnt_lat && state != CORRECT && !flush_i;
  assign last_beat = beat == BEAT_W'(NBEATS - 1);
  assign frame_err = cw_last_i != last_beat;
  assign fail_now  = fail || frame_err;
  assign done      = cw_fire && last_beat;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < T; i++)
      dup = dup || (tbl[i].vld && tbl[i].pos == pos_i);
  end

  assign ev_bad = den_zero_i || pos_i >= POS_W'(N) || dup || coll >= POS_W'(T);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [W-1:0] mask;
    corr_lane_xor u_xor (
      .tbl  (tbl),
      .idx  ((POS_W+1)'(beat) * (POS_W+1)'(LANES) + (POS_W+1)'(l)),
      .mask (mask)
    );
    assign fixed[l*W +: W] = cw_data_i[l*W +: W] ^ (fail_now ? '0 : mask);
  end

  always_comb begin
    state_nx = state;
    if (flush_i)
      state_nx = IDLE;
    else if (state == IDLE)
      state_nx = (ev || cnt_v) ? COLLECT : IDLE;
    else if (state == COLLECT)
      state_nx = (cnt_lat && coll >= err_cnt) ? CORRECT : COLLECT;
    else
      state_nx = done ? IDLE : CORRECT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      tbl        <= '0;
      coll       <= '0;
      err_cnt    <= '0;
      cnt_lat    <= 1'b0;
      fail       <= 1'b0;
      beat       <= '0;
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
      out_last_o <= 1'b0;
      out_fail_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (ev) begin
        if (coll < POS_W'(T)) tbl[coll[CNT_W-1:0]] <= '{vld: 1'b1, pos: pos_i, y: y_i};
        coll <= coll + POS_W'(1);
      end
      if (cnt_v) begin
        err_cnt <= err_cnt_i;
        cnt_lat <= 1'b1;
      end
      fail <= fail || (ev && ev_bad) || (cnt_v && (dec_fail_i || err_cnt_i > POS_W'(T))) ||
              (cw_fire && frame_err);
      if (cw_fire) begin
        beat       <= beat + BEAT_W'(1);
        out_vld_o  <= 1'b1;
        out_data_o <= fixed;
        out_last_o <= last_beat;
        out_fail_o <= fail_now;
      end else if (out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
      if (flush_i || done) begin
        tbl     <= '0;
        coll    <= '0;
        err_cnt <= '0;
        cnt_lat <= 1'b0;
        fail    <= 1'b0;
        beat    <= '0;
      end
      if (flush_i) out_vld_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dec_correct_s3.sv
// tb_dec_correct_s3: directed-vector bench for the RS correction stage.
module tb_dec_correct_s3;
  import dec_pkg::*;
  localparam int DW = LANES * W;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, cnt_vld = 1'b0, dec_fail = 1'b0;
  logic s2_vld = 1'b0, dz = 1'b0, cw_vld = 1'b0, cw_last = 1'b0, out_rdy = 1'b1;
  logic [POS_W-1:0] err_cnt = '0, pos = '0;
  logic [W-1:0] y = '0;
  logic [DW-1:0] cw_data = '0;
  logic s3_rdy, cw_rdy, out_vld, out_last, out_fail;
  logic [DW-1:0] out_data;

  logic [DW-1:0] cw_in [NBEATS], exp_d [NBEATS], got_d [NBEATS];
  logic exp_f [NBEATS], got_f [NBEATS], got_l [NBEATS];
  int n_got, n_assert = 0, n_fail = 0;
  logic held_v, hl, hf;
  logic [DW-1:0] hd;

  dec_correct_s3 dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .err_cnt_vld_i(cnt_vld), .err_cnt_i(err_cnt), .dec_fail_i(dec_fail),
    .s2_vld_i(s2_vld), .s3_rdy_o(s3_rdy), .pos_i(pos), .y_i(y), .den_zero_i(dz),
    .cw_vld_i(cw_vld), .cw_rdy_o(cw_rdy), .cw_data_i(cw_data), .cw_last_i(cw_last),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_data_o(out_data),
    .out_last_o(out_last), .out_fail_o(out_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic send_evt(input int p, input logic [W-1:0] v, input logic d);
    int k;
    @(negedge clk);
    s2_vld = 1'b1; pos = POS_W'(p); y = v; dz = d;
    #1;
    for (k = 0; k < 50 && !s3_rdy; k++) begin @(negedge clk); #1; end
    n_assert++;
    if (k == 50) begin n_fail++; $display("FAIL evt_accept pos=%0d: s3_rdy_o=0, required 1", p); end
    @(posedge clk); #1;
    s2_vld = 1'b0; dz = 1'b0;
  endtask

  task automatic send_cnt(input int c, input logic df);
    @(negedge clk);
    cnt_vld = 1'b1; err_cnt = POS_W'(c); dec_fail = df;
    @(posedge clk); #1;
    cnt_vld = 1'b0; dec_fail = 1'b0;
  endtask

  task automatic fill_cw(input bit pattern);
    for (int b = 0; b < NBEATS; b++) begin
      for (int l = 0; l < LANES; l++)
        cw_in[b][l*W +: W] = pattern ? (W'(b*LANES + l) ^ 10'h155) : 10'h155;
      exp_d[b] = cw_in[b];
      exp_f[b] = 1'b0;
      got_d[b] = 'x;
      got_f[b] = 1'bx;
      got_l[b] = 1'bx;
    end
  endtask

  task automatic flip(input int b, input int l, input logic [W-1:0] v);
    exp_d[b][l*W +: W] = exp_d[b][l*W +: W] ^ v;
  endtask

  task automatic run_cw(input int last_at, input bit toggle);
    n_got = 0;
    held_v = 1'b0;
    fork
      begin
        int k;
        for (int b = 0; b < NBEATS; b++) begin
          @(negedge clk);
          cw_vld = 1'b1; cw_data = cw_in[b]; cw_last = (b == last_at);
          #1;
          for (k = 0; k < 100 && !cw_rdy; k++) begin @(negedge clk); #1; end
          n_assert++;
          if (k == 100) begin
            n_fail++; $display("FAIL cw_accept beat %0d: cw_rdy_o=0, required 1", b);
            break;
          end
          @(posedge clk);
        end
        #1 cw_vld = 1'b0; cw_last = 1'b0;
      end
      begin
        for (int c = 0; c < 400 && n_got < NBEATS; c++) begin
          @(negedge clk);
          out_rdy = toggle ? (c % 2 == 0) : 1'b1;
          #1;
          if (held_v) begin
            n_assert++;
            if (out_vld !== 1'b1 || out_data !== hd || out_last !== hl || out_fail !== hf) begin
              n_fail++;
              $display("FAIL stall_hold: vld=%b data=%h, required vld=1 data=%h", out_vld, out_data, hd);
            end
          end
          held_v = out_vld && !out_rdy; hd = out_data; hl = out_last; hf = out_fail;
          if (out_vld && out_rdy) begin
            got_d[n_got] = out_data; got_f[n_got] = out_fail; got_l[n_got] = out_last;
            n_got++;
          end
        end
        out_rdy = 1'b1;
      end
    join
    @(negedge clk); #1;
    n_assert++;
    if (n_got != NBEATS) begin n_fail++; $display("FAIL beat_count: got %0d, required %0d", n_got, NBEATS); end
    n_assert++;
    if (out_vld !== 1'b0) begin n_fail++; $display("FAIL extra_beat: out_vld_o=%b, required 0", out_vld); end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_assert++;
    if ({out_vld, out_last, out_fail, s3_rdy, cw_rdy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: vld/last/fail/s3rdy/cwrdy=%b, required 00000",
                         {out_vld, out_last, out_fail, s3_rdy, cw_rdy});
    end
    n_assert++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", out_data); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_assert++;
    if (s3_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_rdy: s3_rdy_o=%b, required 1", s3_rdy); end
  endtask

  task automatic test_no_errors();
    fill_cw(1'b0);
    send_cnt(0, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    n_assert++;
    if (s3_rdy !== 1'b0 || cw_rdy !== 1'b1) begin
      n_fail++; $display("FAIL correct_rdy: s3_rdy_o=%b cw_rdy_o=%b, required 0 1", s3_rdy, cw_rdy);
    end
    run_cw(NBEATS - 1, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL noerr_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== exp_f[b]) begin n_fail++; $display("FAIL noerr_fail beat %0d: got %b, required %b", b, got_f[b], exp_f[b]); end
      n_assert++;
      if (got_l[b] !== (b == NBEATS - 1)) begin n_fail++; $display("FAIL noerr_last beat %0d: got %b, required %b", b, got_l[b], b == NBEATS - 1); end
    end
  endtask

  task automatic test_three_events();
    fill_cw(1'b0);
    flip(0, 0, 10'h001); flip(1, 1, 10'h3FF); flip(16, 31, 10'h2AA);
    send_evt(0, 10'h001, 1'b0);
    send_evt(33, 10'h3FF, 1'b0);
    send_evt(543, 10'h2AA, 1'b0);
    send_cnt(3, 1'b0);
    run_cw(NBEATS - 1, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL three_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== 1'b0 || got_l[b] !== (b == NBEATS - 1)) begin
        n_fail++; $display("FAIL three_flags beat %0d: fail=%b last=%b, required 0 %b", b, got_f[b], got_l[b], b == NBEATS - 1);
      end
    end
  endtask

  task automatic test_den_zero();
    fill_cw(1'b0);
    for (int b = 0; b < NBEATS; b++) exp_f[b] = 1'b1;
    send_evt(5, 10'h0AB, 1'b1);
    send_evt(40, 10'h0CD, 1'b0);
    send_cnt(2, 1'b0);
    run_cw(NBEATS - 1, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL denzero_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== 1'b1) begin n_fail++; $display("FAIL denzero_fail beat %0d: got %b, required 1", b, got_f[b]); end
    end
  endtask

  task automatic test_overflow();
    fill_cw(1'b0);
    send_cnt(12, 1'b0);
    for (int i = 0; i < 12; i++) send_evt(i, 10'h001, 1'b0);
    @(negedge clk); #1;
    n_assert++;
    if (s3_rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_rdy_drop: s3_rdy_o=%b, required 0", s3_rdy); end
    run_cw(NBEATS - 1, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL ovf_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== 1'b1) begin n_fail++; $display("FAIL ovf_fail beat %0d: got %b, required 1", b, got_f[b]); end
    end
  endtask

  task automatic test_back_to_back_stall();
    fill_cw(1'b1);
    flip(2, 6, 10'h0F0);
    send_evt(70, 10'h0F0, 1'b0);
    send_cnt(1, 1'b0);
    run_cw(NBEATS - 1, 1'b1);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL stall_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== 1'b0 || got_l[b] !== (b == NBEATS - 1)) begin
        n_fail++; $display("FAIL stall_flags beat %0d: fail=%b last=%b, required 0 %b", b, got_f[b], got_l[b], b == NBEATS - 1);
      end
    end
  endtask

  task automatic test_flush();
    send_cnt(3, 1'b0);
    send_evt(10, 10'h111, 1'b0);
    send_evt(20, 10'h222, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); #1;
    n_assert++;
    if (s3_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: s3_rdy_o=%b out_vld_o=%b, required 1 0", s3_rdy, out_vld);
    end
    fill_cw(1'b0);
    flip(3, 4, 10'h123);
    send_evt(100, 10'h123, 1'b0);
    send_cnt(1, 1'b0);
    run_cw(NBEATS - 1, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL flush_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== 1'b0) begin n_fail++; $display("FAIL flush_fail beat %0d: got %b, required 0", b, got_f[b]); end
    end
  endtask

  task automatic test_framing();
    fill_cw(1'b0);
    flip(0, 2, 10'h011);
    for (int b = 5; b < NBEATS; b++) exp_f[b] = 1'b1;
    send_evt(2, 10'h011, 1'b0);
    send_evt(300, 10'h022, 1'b0);
    send_cnt(2, 1'b0);
    run_cw(5, 1'b0);
    for (int b = 0; b < NBEATS; b++) begin
      n_assert++;
      if (got_d[b] !== exp_d[b]) begin n_fail++; $display("FAIL frame_data beat %0d: got %h, required %h", b, got_d[b], exp_d[b]); end
      n_assert++;
      if (got_f[b] !== exp_f[b]) begin n_fail++; $display("FAIL frame_fail beat %0d: got %b, required %b", b, got_f[b], exp_f[b]); end
      n_assert++;
      if (got_l[b] !== (b == NBEATS - 1)) begin n_fail++; $display("FAIL frame_last beat %0d: got %b, required %b", b, got_l[b], b == NBEATS - 1); end
    end
  endtask

  initial begin
    test_reset();
    test_no_errors();
    test_three_events();
    test_den_zero();
    test_overflow();
    test_back_to_back_stall();
    test_flush();
    test_framing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
